// File: rtl/axis_hdr_tx_pkg.sv
// Shared chain-control definitions: framer FSM states and default bus widths.
package axis_hdr_tx_pkg;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int LEN_WIDTH_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;
endpackage

// File: rtl/axis_reg_slice.sv
// Two-entry AXI-Stream skid slice: registered data/valid and a registered ready,
// so downstream backpressure never reaches upstream ready combinationally.
module axis_reg_slice #(
    parameter int WIDTH = 33
) (
    input  logic             ap_clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] up_data,
    input  logic             up_valid,
    output logic             up_ready,
    output logic [WIDTH-1:0] dn_data,
    output logic             dn_valid,
    input  logic             dn_ready
);
    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;

    // Ready only reflects whether the spare entry is occupied.
    assign up_ready = !skid_valid;

    always_ff @(posedge ap_clk) begin
        if (!resetn) begin
            dn_data    <= '0;
            dn_valid   <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else if (dn_ready || !dn_valid) begin
            if (skid_valid) begin
                dn_data    <= skid_data;
                dn_valid   <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                dn_valid <= up_valid;
                if (up_valid)
                    dn_data <= up_data;
            end
        end else if (up_valid && !skid_valid) begin
            // Output stalled: park the beat that was accepted this cycle.
            skid_data  <= up_data;
            skid_valid <= 1'b1;
        end
    end
endmodule

// File: rtl/axis_hdr_tx.sv
// Transmit framer: one command yields a header beat followed by cmd_tlen payload
// beats, with tlast on the final beat, through a registered skid output stage.
module axis_hdr_tx
    import axis_hdr_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                  ap_clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] cmd_tdata,
    input  logic [LEN_WIDTH-1:0]  cmd_tlen,
    input  logic                  cmd_tvalid,
    output logic                  cmd_tready,
    input  logic [DATA_WIDTH-1:0] in_tdata,
    input  logic                  in_tvalid,
    output logic                  in_tready,
    output logic [DATA_WIDTH-1:0] out_tdata,
    output logic                  out_tlast,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic                  busy
);
    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] hdr;
    logic [LEN_WIDTH-1:0]  len, remaining;
    logic                  cmd_ready_nxt;
    logic                  st_valid, st_ready, st_last;
    logic [DATA_WIDTH-1:0] st_data;
    logic [DATA_WIDTH:0]   out_beat;
    logic                  cmd_fire, st_fire, last_rem;

    assign cmd_fire = cmd_tvalid && cmd_tready;
    assign st_fire  = st_valid && st_ready;
    assign last_rem = (remaining == LEN_WIDTH'(1));

    always_comb begin
        state_nxt     = state;
        cmd_ready_nxt = 1'b0;
        st_valid      = 1'b0;
        st_data       = hdr;
        st_last       = 1'b0;
        in_tready     = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready_nxt = !cmd_fire;
                if (cmd_fire)
                    state_nxt = ST_HDR;
            end
            ST_HDR: begin
                st_valid = 1'b1;
                st_last  = (len == '0);
                if (st_fire) begin
                    state_nxt     = (len == '0) ? ST_IDLE : ST_PAYLOAD;
                    cmd_ready_nxt = (len == '0);
                end
            end
            ST_PAYLOAD: begin
                st_valid  = in_tvalid;
                st_data   = in_tdata;
                st_last   = last_rem;
                in_tready = st_ready;
                if (st_fire && last_rem) begin
                    state_nxt     = ST_IDLE;
                    cmd_ready_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            cmd_tready <= 1'b0;
            busy       <= 1'b0;
            hdr        <= '0;
            len        <= '0;
            remaining  <= '0;
        end else begin
            state      <= state_nxt;
            cmd_tready <= cmd_ready_nxt;
            busy       <= (state_nxt != ST_IDLE);
            if (cmd_fire) begin
                hdr <= cmd_tdata;
                len <= cmd_tlen;
            end
            if (state == ST_HDR && st_fire)
                remaining <= len;
            else if (state == ST_PAYLOAD && st_fire)
                remaining <= remaining - 1'b1;
        end
    end

    axis_reg_slice #(.WIDTH(DATA_WIDTH + 1)) u_out_slice (
        .ap_clk   (ap_clk),
        .resetn   (resetn),
        .up_data  ({st_last, st_data}),
        .up_valid (st_valid),
        .up_ready (st_ready),
        .dn_data  (out_beat),
        .dn_valid (out_tvalid),
        .dn_ready (out_tready)
    );

    assign {out_tlast, out_tdata} = out_beat;
endmodule

// File: tb/tb_axis_hdr_tx.sv
// Directed bench for axis_hdr_tx: framing, latency, backpressure, reset abort, max length.
module tb_axis_hdr_tx;
    logic        ap_clk, resetn;
    logic [31:0] cmd_tdata;
    logic [15:0] cmd_tlen;
    logic        cmd_tvalid, cmd_tready;
    logic [31:0] in_tdata;
    logic        in_tvalid, in_tready;
    logic [31:0] out_tdata;
    logic        out_tlast, out_tvalid, out_tready, busy;

    axis_hdr_tx #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
        .ap_clk(ap_clk), .resetn(resetn),
        .cmd_tdata(cmd_tdata), .cmd_tlen(cmd_tlen), .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
        .out_tdata(out_tdata), .out_tlast(out_tlast), .out_tvalid(out_tvalid), .out_tready(out_tready),
        .busy(busy)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int          vecs = 0;
    int          errs = 0;
    int          cyc  = 0;
    logic [31:0] pay_q[$];
    logic [32:0] got_q[$];
    int          cyc_q[$];
    logic        in_rand = 1'b0;
    logic        in_fire_s = 1'b0, cmd_fire_s = 1'b0, stall_s = 1'b0;
    logic [32:0] stall_beat = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge ap_clk) cyc <= cyc + 1;

    // Handshakes are sampled mid-cycle; each one completes on the following rising edge.
    always @(negedge ap_clk) begin
        in_fire_s  = in_tvalid && in_tready;
        cmd_fire_s = cmd_tvalid && cmd_tready;
        if (resetn && stall_s)
            chk("stall_hold", {31'd0, out_tvalid, out_tlast, out_tdata}, {31'd0, 1'b1, stall_beat});
        stall_s    = resetn && out_tvalid && !out_tready;
        stall_beat = {out_tlast, out_tdata};
        if (resetn && out_tvalid && out_tready) begin
            got_q.push_back({out_tlast, out_tdata});
            cyc_q.push_back(cyc);
        end
    end

    // Payload source: presents the head of pay_q, optionally with random gaps.
    initial begin
        in_tvalid = 1'b0;
        in_tdata  = '0;
        forever begin
            @(posedge ap_clk);
            #1;
            if (in_fire_s && pay_q.size() > 0)
                pay_q.delete(0);
            in_tvalid = (pay_q.size() > 0) && (!in_rand || ($urandom_range(0, 1) == 1));
            in_tdata  = (pay_q.size() > 0) ? pay_q[0] : 32'd0;
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #2;
    endtask

    task automatic send_cmd(input logic [31:0] h, input logic [15:0] l, input logic keep);
        logic ok;
        ok = 1'b0;
        cmd_tdata  = h;
        cmd_tlen   = l;
        cmd_tvalid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (cmd_fire_s) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("cmd_timeout", 64'd0, 64'd1);
        if (!keep) cmd_tvalid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        for (int i = 0; i < budget && got_q.size() < n; i++)
            tick();
        chk("beat_count", 64'(got_q.size()), 64'(n));
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_cmd_tready"}, 64'(cmd_tready), 64'd0);
        chk({tag, "_in_tready"},  64'(in_tready),  64'd0);
        chk({tag, "_out_tvalid"}, 64'(out_tvalid), 64'd0);
        chk({tag, "_out_tdata"},  64'(out_tdata),  64'd0);
        chk({tag, "_out_tlast"},  64'(out_tlast),  64'd0);
        chk({tag, "_busy"},       64'(busy),       64'd0);
    endtask

    initial begin
        int n, bad, lasts;
        resetn     = 1'b0;
        cmd_tdata  = '0;
        cmd_tlen   = '0;
        cmd_tvalid = 1'b0;
        out_tready = 1'b1;
        repeat (3) tick();
        chk_idle_outputs("reset");
        resetn = 1'b1;
        tick();
        chk("cmd_tready_after_reset", 64'(cmd_tready), 64'd1);

        // Packet of 3; payload is already offered in IDLE and must wait.
        pay_q.push_back(32'h11); pay_q.push_back(32'h22); pay_q.push_back(32'h33);
        tick();
        chk("in_tready_idle", 64'(in_tready), 64'd0);
        send_cmd(32'hA5A5_0001, 16'd3, 1'b0);
        chk("hdr_not_yet", 64'(out_tvalid), 64'd0);
        chk("busy_after_cmd", 64'(busy), 64'd1);
        tick();
        chk("hdr_latency_valid", 64'(out_tvalid), 64'd1);
        chk("hdr_latency_data", 64'(out_tdata), 64'hA5A5_0001);
        wait_beats(4, 50);
        chk("p1_b0", 64'(got_q[0]), {31'd0, 1'b0, 32'hA5A5_0001});
        chk("p1_b1", 64'(got_q[1]), {31'd0, 1'b0, 32'h11});
        chk("p1_b2", 64'(got_q[2]), {31'd0, 1'b0, 32'h22});
        chk("p1_b3", 64'(got_q[3]), {31'd0, 1'b1, 32'h33});
        tick();
        chk("p1_busy_done", 64'(busy), 64'd0);
        chk("p1_cmd_tready", 64'(cmd_tready), 64'd1);

        // Zero-length packet: header alone carries tlast.
        got_q.delete();
        send_cmd(32'hDEAD_BEEF, 16'd0, 1'b0);
        chk("len0_busy", 64'(busy), 64'd1);
        chk("len0_cmd_tready_low", 64'(cmd_tready), 64'd0);
        tick();
        chk("len0_cmd_tready_back", 64'(cmd_tready), 64'd1);
        chk("len0_busy_drop", 64'(busy), 64'd0);
        chk("len0_out", {31'd0, out_tvalid, out_tlast, out_tdata}, {31'd0, 2'b11, 32'hDEAD_BEEF});
        repeat (4) tick();
        chk("len0_count", 64'(got_q.size()), 64'd1);
        chk("len0_beat", 64'(got_q[0]), {31'd0, 1'b1, 32'hDEAD_BEEF});

        // Backpressure toggling and random payload gaps.
        got_q.delete();
        pay_q.push_back(32'hB0); pay_q.push_back(32'hB1); pay_q.push_back(32'hB2); pay_q.push_back(32'hB3);
        in_rand = 1'b1;
        send_cmd(32'h0BAD_0004, 16'd4, 1'b0);
        for (int i = 0; i < 300 && got_q.size() < 5; i++) begin
            out_tready = ~out_tready;
            tick();
        end
        out_tready = 1'b1;
        in_rand    = 1'b0;
        repeat (4) tick();
        chk("bp_count", 64'(got_q.size()), 64'd5);
        chk("bp_b0", 64'(got_q[0]), {31'd0, 1'b0, 32'h0BAD_0004});
        chk("bp_b1", 64'(got_q[1]), {31'd0, 1'b0, 32'hB0});
        chk("bp_b2", 64'(got_q[2]), {31'd0, 1'b0, 32'hB1});
        chk("bp_b3", 64'(got_q[3]), {31'd0, 1'b0, 32'hB2});
        chk("bp_b4", 64'(got_q[4]), {31'd0, 1'b1, 32'hB3});

        // Back-to-back commands with cmd_tvalid held high.
        got_q.delete();
        cyc_q.delete();
        pay_q.push_back(32'hC0); pay_q.push_back(32'hC1); pay_q.push_back(32'hC2);
        send_cmd(32'h1111_0001, 16'd2, 1'b1);
        cmd_tdata = 32'h2222_0002;
        cmd_tlen  = 16'd1;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            n++;
            if (n <= 2) chk("b2b_cmd_held_off", 64'(cmd_tready), 64'd0);
            if (cmd_fire_s) break;
        end
        cmd_tvalid = 1'b0;
        chk("b2b_cmd_spacing", 64'(n), 64'd4);
        wait_beats(5, 50);
        chk("b2b_b0", 64'(got_q[0]), {31'd0, 1'b0, 32'h1111_0001});
        chk("b2b_b1", 64'(got_q[1]), {31'd0, 1'b0, 32'hC0});
        chk("b2b_b2", 64'(got_q[2]), {31'd0, 1'b1, 32'hC1});
        chk("b2b_b3", 64'(got_q[3]), {31'd0, 1'b0, 32'h2222_0002});
        chk("b2b_b4", 64'(got_q[4]), {31'd0, 1'b1, 32'hC2});
        chk("b2b_full_rate", 64'(cyc_q[2] - cyc_q[0]), 64'd2);
        chk("b2b_one_gap", 64'(cyc_q[3] - cyc_q[2]), 64'd2);

        // Reset in the middle of a 5-beat packet after two payload beats.
        got_q.delete();
        pay_q.push_back(32'hA1); pay_q.push_back(32'hA2);
        send_cmd(32'h5555_0005, 16'd5, 1'b0);
        wait_beats(3, 50);
        repeat (2) tick();
        resetn = 1'b0;
        tick();
        chk_idle_outputs("midreset");
        resetn = 1'b1;
        tick();
        chk("midreset_cmd_tready", 64'(cmd_tready), 64'd1);
        repeat (4) tick();
        chk("midreset_no_more", 64'(got_q.size()), 64'd3);
        chk("midreset_busy", 64'(busy), 64'd0);
        pay_q.push_back(32'h77);
        send_cmd(32'h0000_0007, 16'd1, 1'b0);
        wait_beats(5, 50);
        chk("after_reset_hdr", 64'(got_q[3]), {31'd0, 1'b0, 32'h7});
        chk("after_reset_pay", 64'(got_q[4]), {31'd0, 1'b1, 32'h77});

        // Maximum length at full rate.
        got_q.delete();
        for (int i = 0; i < 65535; i++) pay_q.push_back(32'(i + 1));
        send_cmd(32'hCAFE_0000, 16'hFFFF, 1'b0);
        wait_beats(65536, 70000);
        repeat (3) tick();
        chk("long_count", 64'(got_q.size()), 64'd65536);
        bad   = 0;
        lasts = 0;
        for (int k = 0; k < got_q.size(); k++) begin
            if (got_q[k][32]) lasts++;
            if (k == 0) begin
                if (got_q[k] !== {1'b0, 32'hCAFE_0000}) bad++;
            end else if (got_q[k][31:0] !== 32'(k)) begin
                bad++;
            end
        end
        chk("long_data", 64'(bad), 64'd0);
        chk("long_tlast_count", 64'(lasts), 64'd1);
        if (got_q.size() == 65536)
            chk("long_final_tlast", 64'(got_q[65535][32]), 64'd1);
        chk("long_busy_done", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
